// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read slave among NUM_MASTERS read masters.
// One burst in flight at a time; R path is combinational back to the granted master.
module axi_rd_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 8
) (
    input  logic                              axi_clk,
    input  logic                              axi_reset,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_arid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [NUM_MASTERS*8-1:0]          s_axi_arlen,
    input  logic [NUM_MASTERS-1:0]            s_axi_arvalid,
    output logic [NUM_MASTERS-1:0]            s_axi_arready,
    output logic [NUM_MASTERS*ID_WIDTH-1:0]   s_axi_rid,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] s_axi_rdata,
    output logic [NUM_MASTERS*2-1:0]          s_axi_rresp,
    output logic [NUM_MASTERS-1:0]            s_axi_rlast,
    output logic [NUM_MASTERS-1:0]            s_axi_rvalid,
    input  logic [NUM_MASTERS-1:0]            s_axi_rready,
    output logic [ID_WIDTH-1:0]               m_axi_arid,
    output logic [ADDR_WIDTH-1:0]             m_axi_araddr,
    output logic [7:0]                        m_axi_arlen,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [ID_WIDTH-1:0]               m_axi_rid,
    input  logic [DATA_WIDTH-1:0]             m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rlast,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                 state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          last_grant;
    logic [GW-1:0]          winner;
    logic [NUM_MASTERS-1:0] grant_oh;
    logic                   sel_arvalid;
    logic                   sel_rready;

    // Scan upward from the master after last_grant, wrapping, for the first requester.
    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = last_grant;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_grant) + k) % NUM_MASTERS;
            if (!found && s_axi_arvalid[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axi_arvalid) begin
                        grant <= winner;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    // A requester withdrawing before the handshake forfeits its turn silently.
                    if (sel_arvalid && m_axi_arready) begin
                        state <= DATA;
                    end else if (!sel_arvalid) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (m_axi_rvalid && sel_rready && m_axi_rlast) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        grant_oh     = '0;
        sel_arvalid  = 1'b0;
        sel_rready   = 1'b0;
        m_axi_arid   = '0;
        m_axi_araddr = '0;
        m_axi_arlen  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (GW'(i) == grant) begin
                grant_oh[i]  = 1'b1;
                sel_arvalid  = s_axi_arvalid[i];
                sel_rready   = s_axi_rready[i];
                m_axi_arid   = s_axi_arid[i*ID_WIDTH +: ID_WIDTH];
                m_axi_araddr = s_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_axi_arlen  = s_axi_arlen[i*8 +: 8];
            end
        end
        m_axi_arvalid = (state == ADDR) && sel_arvalid;
        s_axi_arready = (state == ADDR && m_axi_arready) ? grant_oh : '0;
        s_axi_rvalid  = (state == DATA && m_axi_rvalid) ? grant_oh : '0;
        m_axi_rready  = (state == DATA) && sel_rready;
    end

    assign s_axi_rid   = {NUM_MASTERS{m_axi_rid}};
    assign s_axi_rdata = {NUM_MASTERS{m_axi_rdata}};
    assign s_axi_rresp = {NUM_MASTERS{m_axi_rresp}};
    assign s_axi_rlast = {NUM_MASTERS{m_axi_rlast}};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: bench plays both upstream masters and the downstream slave.
module tb_axi_rd_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 8;

    logic            axi_clk;
    logic            axi_reset;
    logic [N*IW-1:0] s_axi_arid;
    logic [N*AW-1:0] s_axi_araddr;
    logic [N*8-1:0]  s_axi_arlen;
    logic [N-1:0]    s_axi_arvalid;
    logic [N-1:0]    s_axi_arready;
    logic [N*IW-1:0] s_axi_rid;
    logic [N*DW-1:0] s_axi_rdata;
    logic [N*2-1:0]  s_axi_rresp;
    logic [N-1:0]    s_axi_rlast;
    logic [N-1:0]    s_axi_rvalid;
    logic [N-1:0]    s_axi_rready;
    logic [IW-1:0]   m_axi_arid;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [IW-1:0]   m_axi_rid;
    logic [DW-1:0]   m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic            m_axi_rvalid;
    logic            m_axi_rready;

    logic [7:0]      cur_len;

    axi_rd_arbiter #(
        .NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)
    ) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    assign s_axi_arid   = {8'h5A, 8'hA0};
    assign s_axi_araddr = {32'h0000_2000, 32'h0000_1000};
    assign s_axi_arlen  = {cur_len, cur_len};

    int n_vec;
    int n_bad;

    typedef struct {
        logic [1:0] req;
        logic [7:0] len;
        bit         tog;
        int         exp_g;
        int         exp_beats;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int b);
        return 32'hC0DE_0000 | DW'(b);
    endfunction

    // Entered and left just after a rising edge.
    task automatic run_burst(input logic [1:0] req, input logic [7:0] len, input bit tog,
                             input int exp_g, input int exp_beats);
        int         beats;
        int         cyc;
        bit         done;
        logic       rr;
        logic [7:0] exp_id;
        logic [31:0] exp_addr;
        exp_id   = (exp_g == 1) ? 8'h5A : 8'hA0;
        exp_addr = (exp_g == 1) ? 32'h0000_2000 : 32'h0000_1000;
        s_axi_arvalid = req;
        cur_len       = len;
        m_axi_arready = 1'b1;
        @(negedge axi_clk);
        check("bubble_arvalid", 64'(m_axi_arvalid), 64'(0));
        check("bubble_arready", 64'(s_axi_arready), 64'(0));
        @(posedge axi_clk); #1;
        @(negedge axi_clk);
        check("ar_valid", 64'(m_axi_arvalid), 64'(1));
        check("ar_id", 64'(m_axi_arid), 64'(exp_id));
        check("ar_addr", 64'(m_axi_araddr), 64'(exp_addr));
        check("ar_len", 64'(m_axi_arlen), 64'(len));
        check("ar_ready_grant", 64'(s_axi_arready), 64'(1) << exp_g);
        @(posedge axi_clk); #1;
        beats = 0;
        cyc   = 0;
        done  = 1'b0;
        while (!done && cyc < 2000) begin
            rr = tog ? (cyc % 2 == 0) : 1'b1;
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_data(beats);
            m_axi_rresp  = 2'(beats);
            m_axi_rid    = exp_id;
            m_axi_rlast  = (beats == int'(len));
            s_axi_rready = 2'b11;
            s_axi_rready[exp_g] = rr;
            @(negedge axi_clk);
            check("r_valid_route", 64'(s_axi_rvalid), 64'(1) << exp_g);
            check("r_ready_route", 64'(m_axi_rready), 64'(rr));
            check("r_data", 64'(s_axi_rdata[exp_g*DW +: DW]), 64'(beat_data(beats)));
            check("r_last", 64'(s_axi_rlast[exp_g]), 64'(beats == int'(len)));
            check("data_arready", 64'(s_axi_arready), 64'(0));
            @(posedge axi_clk); #1;
            if (rr) begin
                if (beats == int'(len)) done = 1'b1;
                beats++;
            end
            cyc++;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        s_axi_rready = 2'b11;
        check("beat_count", 64'(beats), 64'(exp_beats));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        vt[0]  = '{req: 2'b10, len: 8'd3,   tog: 1'b0, exp_g: 1, exp_beats: 4};
        vt[1]  = '{req: 2'b11, len: 8'd0,   tog: 1'b0, exp_g: 0, exp_beats: 1};
        vt[2]  = '{req: 2'b11, len: 8'd0,   tog: 1'b0, exp_g: 1, exp_beats: 1};
        vt[3]  = '{req: 2'b11, len: 8'd0,   tog: 1'b0, exp_g: 0, exp_beats: 1};
        vt[4]  = '{req: 2'b11, len: 8'd0,   tog: 1'b0, exp_g: 1, exp_beats: 1};
        vt[5]  = '{req: 2'b11, len: 8'd0,   tog: 1'b0, exp_g: 0, exp_beats: 1};
        vt[6]  = '{req: 2'b11, len: 8'd0,   tog: 1'b0, exp_g: 1, exp_beats: 1};
        vt[7]  = '{req: 2'b10, len: 8'd0,   tog: 1'b0, exp_g: 1, exp_beats: 1};
        vt[8]  = '{req: 2'b11, len: 8'd7,   tog: 1'b1, exp_g: 0, exp_beats: 8};
        vt[9]  = '{req: 2'b10, len: 8'd255, tog: 1'b0, exp_g: 1, exp_beats: 256};
        vt[10] = '{req: 2'b01, len: 8'd2,   tog: 1'b0, exp_g: 0, exp_beats: 3};

        axi_reset     = 1'b1;
        s_axi_arvalid = '0;
        s_axi_rready  = '0;
        cur_len       = '0;
        m_axi_arready = 1'b0;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = '0;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;

        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        check("rst_arready", 64'(s_axi_arready), 64'(0));
        check("rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("rst_m_arvalid", 64'(m_axi_arvalid), 64'(0));
        check("rst_m_rready", 64'(m_axi_rready), 64'(0));
        @(posedge axi_clk); #1;
        axi_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge axi_clk);
            check("idle_m_arvalid", 64'(m_axi_arvalid), 64'(0));
        end
        @(posedge axi_clk); #1;

        for (int v = 0; v < 11; v++) begin
            run_burst(vt[v].req, vt[v].len, vt[v].tog, vt[v].exp_g, vt[v].exp_beats);
        end

        // Reset in the middle of a 16-beat burst from master 0.
        s_axi_arvalid = 2'b01;
        cur_len       = 8'd15;
        m_axi_arready = 1'b1;
        @(posedge axi_clk); #1;
        @(negedge axi_clk);
        check("mid_ar_valid", 64'(m_axi_arvalid), 64'(1));
        @(posedge axi_clk); #1;
        s_axi_arvalid = 2'b00;
        for (int b = 0; b < 3; b++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_data(b);
            m_axi_rlast  = 1'b0;
            if (b < 2) begin
                @(posedge axi_clk); #1;
            end
        end
        @(negedge axi_clk);
        check("mid_rvalid_pre", 64'(s_axi_rvalid), 64'(1));
        #1;
        axi_reset     = 1'b1;
        s_axi_arvalid = 2'b11;
        #1;
        check("mid_rst_rvalid", 64'(s_axi_rvalid), 64'(0));
        check("mid_rst_rready", 64'(m_axi_rready), 64'(0));
        check("mid_rst_m_arvalid", 64'(m_axi_arvalid), 64'(0));
        check("mid_rst_arready", 64'(s_axi_arready), 64'(0));
        m_axi_rvalid = 1'b0;
        repeat (2) @(posedge axi_clk);
        #1;
        axi_reset = 1'b0;
        run_burst(2'b11, 8'd1, 1'b0, 0, 2);

        // Master 1 withdraws in ADDR; its turn must not count.
        m_axi_arready = 1'b0;
        s_axi_arvalid = 2'b10;
        cur_len       = 8'd0;
        @(negedge axi_clk);
        check("abort_bubble", 64'(m_axi_arvalid), 64'(0));
        @(posedge axi_clk); #1;
        @(negedge axi_clk);
        check("abort_ar_valid", 64'(m_axi_arvalid), 64'(1));
        check("abort_arready", 64'(s_axi_arready), 64'(0));
        @(posedge axi_clk); #1;
        s_axi_arvalid = 2'b00;
        @(negedge axi_clk);
        check("abort_drop", 64'(m_axi_arvalid), 64'(0));
        @(posedge axi_clk); #1;
        run_burst(2'b11, 8'd0, 1'b0, 1, 1);

        s_axi_arvalid = 2'b00;
        repeat (2) @(posedge axi_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
